// File: rtl/pwm_pkg.sv
// +--------------------------------------------------------------------------+
// | Module : pwm_pkg                                                         |
// | Brief  : Shared types and defaults for the PWM capture block.            |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package pwm_pkg;

    localparam int c_default_cnt_width = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_cap_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_in_sync.sv
// +--------------------------------------------------------------------------+
// | Module : pwm_in_sync                                                     |
// | Brief  : pwm_in synchronizer, optional glitch filter (enabled by the     |
// |          PWM_CAPTURE_FILTER_EN macro) and registered edge detect.        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pwm_in_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_lvl;
    logic                   r_lvl_d;
    logic                   r_rise;
    logic                   r_fall;

    // Out-of-range configurations are not supported; nothing is elaborated for them.
    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_invalid
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int c_fcnt_width = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic                    r_flt;
    logic [c_fcnt_width-1:0] r_fcnt;

    // The new level must be seen FILTER_LEN cycles in a row before it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flt  <= 1'b0;
            r_fcnt <= '0;
        end else if (w_sync == r_flt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == c_fcnt_width'(FILTER_LEN - 1)) begin
            r_flt  <= w_sync;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    assign w_lvl = r_flt;
`else
    assign w_lvl = w_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl_d <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_lvl_d <= w_lvl;
            r_rise  <= w_lvl & ~r_lvl_d;
            r_fall  <= ~w_lvl & r_lvl_d;
        end
    end

    // lvl is the delayed copy so that it is aligned with the rise/fall flags.
    assign lvl  = r_lvl_d;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// +--------------------------------------------------------------------------+
// | Module : pwm_capture                                                     |
// | Brief  : Measures PWM period and high time in clk cycles, flags stuck    |
// |          inputs. Glitch filter enabled by PWM_CAPTURE_FILTER_EN.         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH   = c_default_cnt_width,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period_count,
    output logic [CNT_WIDTH-1:0] high_count,
    output logic                 meas_valid,
    output logic                 stuck,
    output logic                 stuck_level
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic w_lvl;
    logic w_rise;
    logic w_fall;

    pwm_cap_state_t       r_state,        w_state_nxt;
    logic [CNT_WIDTH-1:0] r_pcnt,         w_pcnt_nxt;
    logic [CNT_WIDTH-1:0] r_hcnt,         w_hcnt_nxt;
    logic [CNT_WIDTH-1:0] r_period_count, w_period_nxt;
    logic [CNT_WIDTH-1:0] r_high_count,   w_high_nxt;
    logic                 r_meas_valid,   w_valid_nxt;
    logic                 r_stuck,        w_stuck_nxt;
    logic                 r_stuck_level,  w_stuck_level_nxt;
    logic [CNT_WIDTH-1:0] w_pcnt_inc;

    pwm_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_in_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .lvl    (w_lvl),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    assign w_pcnt_inc = (r_pcnt == c_cnt_max) ? r_pcnt : r_pcnt + 1'b1;

    always_comb begin
        w_state_nxt       = r_state;
        w_pcnt_nxt        = r_pcnt;
        w_hcnt_nxt        = r_hcnt;
        w_period_nxt      = r_period_count;
        w_high_nxt        = r_high_count;
        w_valid_nxt       = 1'b0;
        w_stuck_nxt       = r_stuck;
        w_stuck_level_nxt = r_stuck_level;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = HIGH;
                    w_pcnt_nxt  = c_cnt_one;
                    w_stuck_nxt = 1'b0;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_state_nxt = LOW;
                    w_hcnt_nxt  = r_pcnt;
                    w_pcnt_nxt  = w_pcnt_inc;
                end else if (r_pcnt == c_cnt_max) begin
                    w_state_nxt       = IDLE;
                    w_stuck_nxt       = 1'b1;
                    w_stuck_level_nxt = w_lvl;
                end else begin
                    w_pcnt_nxt = w_pcnt_inc;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_state_nxt  = HIGH;
                    w_period_nxt = r_pcnt;
                    w_high_nxt   = r_hcnt;
                    w_valid_nxt  = 1'b1;
                    w_pcnt_nxt   = c_cnt_one;
                end else if (r_pcnt == c_cnt_max) begin
                    w_state_nxt       = IDLE;
                    w_stuck_nxt       = 1'b1;
                    w_stuck_level_nxt = w_lvl;
                end else begin
                    w_pcnt_nxt = w_pcnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_pcnt         <= '0;
            r_hcnt         <= '0;
            r_period_count <= '0;
            r_high_count   <= '0;
            r_meas_valid   <= 1'b0;
            r_stuck        <= 1'b0;
            r_stuck_level  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pcnt         <= w_pcnt_nxt;
            r_hcnt         <= w_hcnt_nxt;
            r_period_count <= w_period_nxt;
            r_high_count   <= w_high_nxt;
            r_meas_valid   <= w_valid_nxt;
            r_stuck        <= w_stuck_nxt;
            r_stuck_level  <= w_stuck_level_nxt;
        end
    end

    assign period_count = r_period_count;
    assign high_count   = r_high_count;
    assign meas_valid   = r_meas_valid;
    assign stuck        = r_stuck;
    assign stuck_level  = r_stuck_level;

endmodule

`default_nettype wire
